apb_mem_completer: RTL and testbench



---
 rtl/apb_mem_completer.sv | 179 +++++++++++++++++
 tb/tb_apb_mem_completer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_completer.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_completer
// Brief    : APB completer for a word-addressed memory with per-transfer wait
//            states. Optional macro APB_COMPLETER_PSLVERR_EN enables PSLVERR
//            and misaligned-address detection.
// Revision : 1.0 - initial release
// ============================================================================
module apb_mem_completer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    input  logic [3:0]            wait_cycles
);

    localparam int c_BYTE_LSB = $clog2(DATA_WIDTH / 8);
    localparam int c_IDX_W    = $clog2(MEM_DEPTH);
    localparam int c_TOP      = c_BYTE_LSB + c_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_bad;
    logic                  r_pready;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_setup;
    logic                  w_commit;
    logic                  w_out_of_range;
    logic                  w_misaligned;
    logic                  w_bad;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_c_write;
    logic [c_IDX_W-1:0]    w_c_idx;
    logic [DATA_WIDTH-1:0] w_c_wdata;
    logic                  w_c_bad;

    assign w_idx = PADDR[c_BYTE_LSB +: c_IDX_W];

    generate
        if (ADDR_WIDTH > c_TOP) begin : g_range
            assign w_out_of_range = |PADDR[ADDR_WIDTH-1:c_TOP];
        end else begin : g_no_range
            assign w_out_of_range = 1'b0;
        end
        if (c_BYTE_LSB > 0) begin : g_align
            assign w_misaligned = |PADDR[c_BYTE_LSB-1:0];
        end else begin : g_no_align
            assign w_misaligned = 1'b0;
        end
    endgenerate

`ifdef APB_COMPLETER_PSLVERR_EN
    assign w_bad = w_out_of_range | w_misaligned;
`else
    // Without error reporting, the byte-offset bits are simply ignored.
    logic w_unused_align;
    assign w_unused_align = w_misaligned;
    assign w_bad          = w_out_of_range;
`endif

    // A zero-wait transfer commits straight from the setup cycle, so take the live bus values.
    assign w_c_write = (r_state == S_IDLE) ? PWRITE : r_write;
    assign w_c_idx   = (r_state == S_IDLE) ? w_idx  : r_idx;
    assign w_c_wdata = (r_state == S_IDLE) ? PWDATA : r_wdata;
    assign w_c_bad   = (r_state == S_IDLE) ? w_bad  : r_bad;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_setup     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_setup = 1'b1;
                    if (wait_cycles == 4'd0) begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_bad    <= 1'b0;
            r_pready <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_pready <= w_commit;
            if (w_setup) begin
                r_cnt   <= wait_cycles;
                r_write <= PWRITE;
                r_idx   <= w_idx;
                r_wdata <= PWDATA;
                r_bad   <= w_bad;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && w_c_bad) begin
                r_prdata <= '0;
            end else if (w_commit && !w_c_write) begin
                r_prdata <= r_mem[w_c_idx];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET && w_commit && w_c_write && !w_c_bad) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
    end

`ifdef APB_COMPLETER_PSLVERR_EN
    logic r_pslverr;
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_commit & w_c_bad;
        end
    end
    assign PSLVERR = r_pslverr;
`else
    assign PSLVERR = 1'b0;
`endif

    assign PREADY = r_pready;
    assign PRDATA = r_prdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_completer.sv
`default_nettype none
// Directed bench for apb_mem_completer; expectations follow the
// APB_COMPLETER_PSLVERR_EN setting of the build.
module tb_apb_mem_completer;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [3:0]  wait_cycles = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rcyc;
    logic [31:0] rd;
    logic        err;
    int          hits;

`ifdef APB_COMPLETER_PSLVERR_EN
    localparam logic        c_ERR_EN   = 1'b1;
    localparam logic [31:0] c_MIS_DATA = 32'h0;
`else
    localparam logic        c_ERR_EN   = 1'b0;
    localparam logic [31:0] c_MIS_DATA = 32'hA5A5_0001;
`endif

    apb_mem_completer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_DEPTH (256)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR),
        .wait_cycles(wait_cycles)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer; leaves PSEL asserted so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] n, output logic [31:0] cyc,
                        output logic [31:0] data, output logic e);
        cyc  = 32'hFFFF_FFFF;
        data = 32'hXXXX_XXXX;
        e    = 1'bx;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        wait_cycles = n;
        for (int k = 1; k <= 20; k++) begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
            wait_cycles = ~n;
            if (PREADY) begin
                cyc  = k;
                data = PRDATA;
                e    = PSLVERR;
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge PCLK);
        #1;
        check("reset_pready",  {31'b0, PREADY},  32'h0);
        check("reset_prdata",  PRDATA,           32'h0);
        check("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
        PRESET = 1'b0;

        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'd0, rcyc, rd, err);
        check("wr0_ready_cycle", rcyc, 32'd1);
        check("wr0_pslverr", {31'b0, err}, 32'h0);
        xfer(1'b0, 32'h10, 32'h0, 4'd0, rcyc, rd, err);
        check("rd0_ready_cycle", rcyc, 32'd1);
        check("rd0_data", rd, 32'hDEAD_BEEF);
        idle();
        check("rd0_pulse_one_cycle", {31'b0, PREADY}, 32'h0);

        xfer(1'b0, 32'h10, 32'h0, 4'd3, rcyc, rd, err);
        check("rd3_ready_cycle", rcyc, 32'd4);
        check("rd3_data", rd, 32'hDEAD_BEEF);
        idle();
        check("rd3_pulse_one_cycle", {31'b0, PREADY}, 32'h0);
        check("rd3_prdata_hold", PRDATA, 32'hDEAD_BEEF);

        xfer(1'b1, 32'h4, 32'h1234_5678, 4'd0, rcyc, rd, err);
        check("b2b_wr_ready_cycle", rcyc, 32'd1);
        xfer(1'b0, 32'h4, 32'h0, 4'd1, rcyc, rd, err);
        check("b2b_rd_ready_cycle", rcyc, 32'd2);
        check("b2b_rd_data", rd, 32'h1234_5678);

        xfer(1'b1, 32'h0, 32'hA5A5_0001, 4'd2, rcyc, rd, err);
        check("wr_idx0_ready_cycle", rcyc, 32'd3);
        xfer(1'b1, 32'h400, 32'hBAD0_BAD0, 4'd0, rcyc, rd, err);
        check("oor_wr_pslverr", {31'b0, err}, {31'b0, c_ERR_EN});
        xfer(1'b0, 32'h0, 32'h0, 4'd0, rcyc, rd, err);
        check("oor_wr_dropped", rd, 32'hA5A5_0001);
        check("good_rd_pslverr", {31'b0, err}, 32'h0);
        xfer(1'b0, 32'h2, 32'h0, 4'd1, rcyc, rd, err);
        check("mis_rd_pslverr", {31'b0, err}, {31'b0, c_ERR_EN});
        check("mis_rd_data", rd, c_MIS_DATA);
        xfer(1'b0, 32'h404, 32'h0, 4'd0, rcyc, rd, err);
        check("oor_rd_data", rd, 32'h0);
        check("oor_rd_pslverr", {31'b0, err}, {31'b0, c_ERR_EN});
        idle();

        // Requester abandons a wait_cycles=5 write partway through WAIT.
        hits = 0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h1111_1111;
        wait_cycles = 4'd5;
        for (int k = 0; k < 10; k++) begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
            if (PREADY) hits++;
            if (k == 2) begin PSEL = 1'b0; PENABLE = 1'b0; end
        end
        check("abort_no_pready", hits, 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 4'd0, rcyc, rd, err);
        check("abort_old_data", rd, 32'hDEAD_BEEF);
        idle();

        // Access phase without a setup phase must be ignored.
        hits = 0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h3333_3333;
        wait_cycles = 4'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge PCLK); #1;
            if (PREADY) hits++;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        check("no_setup_ignored", hits, 32'd0);

        // Reset during WAIT of a write.
        xfer(1'b0, 32'h4, 32'h0, 4'd0, rcyc, rd, err);
        check("pre_rst_rd_data", rd, 32'h1234_5678);
        idle();
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h2222_2222;
        wait_cycles = 4'd4;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("midrst_pready",  {31'b0, PREADY},  32'h0);
        check("midrst_prdata",  PRDATA,           32'h0);
        check("midrst_pslverr", {31'b0, PSLVERR}, 32'h0);
        PRESET = 1'b0;
        xfer(1'b0, 32'h4, 32'h0, 4'd2, rcyc, rd, err);
        check("post_rst_ready_cycle", rcyc, 32'd3);
        check("post_rst_old_data", rd, 32'h1234_5678);
        idle();
        xfer(1'b0, 32'h10, 32'h0, 4'd0, rcyc, rd, err);
        check("post_rst_persist", rd, 32'hDEAD_BEEF);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
